// File: rtl/aes_block_loader.sv
// aes_block_loader: packs a 32-bit word stream into the 128-bit key/plaintext buses of a combinational AES-128 core.
// Latency: the core output is captured and m_valid rises SETTLE_CYCLES edges after the last data word is accepted.
// Backpressure: s_ready is low from the last data word until the result handshake; m_valid holds until m_ready.
// Optional build macro AES_LOADER_ERR_EN adds a sticky 'err' output for protocol misuse.
module aes_block_loader #(
  // Cycles the core inputs stay stable before capture; legal range 1..15.
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_key,
  output logic [127:0] aes_in,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_out,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         busy
`ifdef AES_LOADER_ERR_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY    = 3'd1,
    ST_DATA   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t       r_state;
  logic [1:0]   r_cnt;
  logic [3:0]   r_settle;
  logic         r_live;
  logic [127:0] r_key;
  logic [127:0] r_data;
  logic         r_m_valid;
  logic [127:0] r_m_data;

  state_t       w_state_nxt;
  logic [1:0]   w_cnt_nxt;
  logic [3:0]   w_settle_nxt;
  logic         w_key_ld;
  logic         w_data_ld;
  logic         w_capture;
  logic         w_release;
  logic         w_s_ready;
  logic         w_accept;

  // r_live keeps s_ready low while reset is asserted; otherwise ready depends only on state.
  assign w_s_ready = r_live &&
                     ((r_state == ST_IDLE) || (r_state == ST_KEY) || (r_state == ST_DATA));
  assign w_accept  = s_valid && w_s_ready;

  assign s_ready = w_s_ready;
  assign aes_in  = r_data;
  assign aes_key = r_key;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign busy    = (r_state != ST_IDLE);

  // State, word counter and settle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 2'd0;
      r_settle <= 4'd0;
      r_live   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_settle <= w_settle_nxt;
      r_live   <= 1'b1;
    end
  end

  // Next-state logic and datapath strobes; s_key only steers the first word of a frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_settle_nxt = r_settle;
    w_key_ld     = 1'b0;
    w_data_ld    = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = 2'd1;
          if (s_key) begin
            w_key_ld    = 1'b1;
            w_state_nxt = ST_KEY;
          end else begin
            w_data_ld   = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_KEY: begin
        if (w_accept) begin
          w_key_ld  = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;      // wraps to 0 after the 4th key word
          if (r_cnt == 2'd3) begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_data_ld = 1'b1;
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = SETTLE_INIT;
          end
        end
      end
      ST_SETTLE: begin
        if (r_settle == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_settle_nxt = r_settle - 4'd1;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Assembly shift registers double as the core input buses; the key persists across frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key  <= 128'd0;
      r_data <= 128'd0;
    end else begin
      if (w_key_ld) begin
        r_key <= {r_key[95:0], s_data};
      end
      if (w_data_ld) begin
        r_data <= {r_data[95:0], s_data};
      end
    end
  end

  // Result register: captures the core output once settled; m_data holds after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= 128'd0;
    end else begin
      if (w_capture) begin
        r_m_valid <= 1'b1;
        r_m_data  <= aes_out;
      end else if (w_release) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef AES_LOADER_ERR_EN
  logic r_err;
  logic r_key_ok;
  logic r_key_frame;

  assign err = r_err;

  // Sticky misuse flag: s_key on a non-first word, or a data frame before any complete key frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_key_ok    <= 1'b0;
      r_key_frame <= 1'b0;
    end else begin
      if (w_accept && s_key && (r_state != ST_IDLE)) begin
        r_err <= 1'b1;
      end
      if (w_accept && !s_key && (r_state == ST_IDLE) && !r_key_ok) begin
        r_err <= 1'b1;
      end
      if (w_accept && s_key && (r_state == ST_IDLE)) begin
        r_key_frame <= 1'b1;
      end
      if (w_data_ld && (w_state_nxt == ST_SETTLE)) begin
        r_key_frame <= 1'b0;
        if (r_key_frame) begin
          r_key_ok <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader with the core modelled as aes_out = aes_in ^ aes_key.
// Expected ciphertexts are pushed into a queue by the stimulus; a monitor pops them on each result handshake.
module tb_aes_block_loader;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_key;
  logic [127:0] aes_in;
  logic [127:0] aes_key;
  logic [127:0] aes_out;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         busy;
`ifdef AES_LOADER_ERR_EN
  logic         err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int busy_bad = 0;
  bit busy_window = 0;
  logic [127:0] sb_q[$];

  localparam logic [127:0] KEY_A   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] PT_A    = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT_A    = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
  localparam logic [127:0] PT_F    = 128'hffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [127:0] CT_F    = 128'hfffefdfc_fbfaf9f8_f7f6f5f4_f3f2f1f0;
  localparam logic [127:0] PT_B    = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] CT_B    = 128'h11101312_26272425_3b3a3938_48494a4b;
  localparam logic [127:0] PT_0    = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] PT_R    = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  assign aes_out = aes_in ^ aes_key;

  aes_block_loader dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_key   (s_key),
    .aes_in  (aes_in),
    .aes_key (aes_key),
    .aes_out (aes_out),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy)
`ifdef AES_LOADER_ERR_EN
    ,
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a result handshake happens on the edge after a negedge with m_valid && m_ready.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %h with nothing expected", m_data);
      end else begin
        chk("sb_m_data", m_data, sb_q.pop_front());
      end
    end
    if (busy_window && !busy) busy_bad++;
  end

  // Offer one word and return just after the edge that accepts it.
  task automatic send_word(input logic [31:0] d, input logic k, input bit gaps);
    int t;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_key   = k;
    t = 0;
    while (!s_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_key   = 1'b0;
  endtask

  task automatic send_frame(input bit kf, input logic [127:0] k, input logic [127:0] d,
                            input bit gaps);
    if (kf) begin
      for (int i = 0; i < 4; i++) begin
        send_word(k[127-32*i -: 32], (i == 0), gaps);
        if (i == 0 && gaps) busy_window = 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_word(d[127-32*i -: 32], 1'b0, gaps);
    end
  endtask

  // Called just after the last data word's edge E0: m_valid must rise after E2.
  task automatic check_latency(input string tag);
    chk({tag, "_mv_e0"}, {127'd0, m_valid}, 128'd0);
    chk({tag, "_srdy_e0"}, {127'd0, s_ready}, 128'd0);
    @(posedge clk); #1;
    chk({tag, "_mv_e1"}, {127'd0, m_valid}, 128'd0);
    @(posedge clk); #1;
    chk({tag, "_mv_e2"}, {127'd0, m_valid}, 128'd1);
  endtask

  task automatic check_back_to_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_mv_drop"}, {127'd0, m_valid}, 128'd0);
    chk({tag, "_busy_idle"}, {127'd0, busy}, 128'd0);
    chk({tag, "_srdy_idle"}, {127'd0, s_ready}, 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_srdy"}, {127'd0, s_ready}, 128'd0);
    chk({tag, "_mv"}, {127'd0, m_valid}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_mdata"}, m_data, 128'd0);
    chk({tag, "_aes_in"}, aes_in, 128'd0);
    chk({tag, "_aes_key"}, aes_key, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] snap_md;
    logic [127:0] snap_in;
    int bp_bad;

    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_key = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
`ifdef AES_LOADER_ERR_EN
    chk("rst0_err", {127'd0, err}, 128'd0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_srdy", {127'd0, s_ready}, 128'd1);

    // Data frame with no key loaded yet: key is zero, so the result is the plaintext.
    sb_q.push_back(PT_0);
    send_frame(1'b0, 128'd0, PT_0, 1'b0);
    chk("df0_aes_in", aes_in, PT_0);
    check_latency("df0");
    check_back_to_idle("df0");
`ifdef AES_LOADER_ERR_EN
    chk("df0_err", {127'd0, err}, 128'd1);
`endif

    // Back-to-back key frame.
    sb_q.push_back(CT_A);
    send_frame(1'b1, KEY_A, PT_A, 1'b0);
    chk("kf_aes_key", aes_key, KEY_A);
    chk("kf_aes_in", aes_in, PT_A);
    check_latency("kf");
    check_back_to_idle("kf");

    // Data frame reusing the stored key.
    sb_q.push_back(CT_F);
    send_frame(1'b0, 128'd0, PT_F, 1'b0);
    chk("df_key_reuse", aes_key, KEY_A);
    check_latency("dff");
    check_back_to_idle("dff");

    // Backpressure: hold m_ready low for 20 cycles while offering words.
    m_ready = 1'b0;
    sb_q.push_back(CT_B);
    send_frame(1'b0, 128'd0, PT_B, 1'b0);
    check_latency("bp");
    snap_md = m_data;
    snap_in = aes_in;
    chk("bp_mdata", snap_md, CT_B);
    bp_bad = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 32'h5a5a5a5a; s_key = 1'b1;
      @(posedge clk); #1;
      if (m_valid !== 1'b1 || m_data !== snap_md || s_ready !== 1'b0 || aes_in !== snap_in)
        bp_bad++;
    end
    s_valid = 1'b0; s_key = 1'b0;
    chk("bp_stable_cycles_bad", 128'(bp_bad), 128'd0);
    m_ready = 1'b1;
    check_back_to_idle("bp");
    chk("bp_mdata_hold", m_data, CT_B);

    // Key frame with random s_valid gaps: same result as back-to-back.
    busy_bad = 0;
    sb_q.push_back(CT_A);
    send_frame(1'b1, KEY_A, PT_A, 1'b1);
    chk("gap_aes_key", aes_key, KEY_A);
    chk("gap_aes_in", aes_in, PT_A);
    check_latency("gap");
    @(posedge clk); #1;
    busy_window = 0;
    chk("gap_busy_drops_bad", 128'(busy_bad), 128'd0);
    chk("gap_busy_idle", {127'd0, busy}, 128'd0);

    // Asynchronous reset after the 6th word of a key frame.
    for (int i = 0; i < 4; i++) send_word(PT_R[127-32*i -: 32], (i == 0), 1'b0);
    for (int i = 0; i < 2; i++) send_word(KEY_A[127-32*i -: 32], 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("amid");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("amid_rel_srdy", {127'd0, s_ready}, 128'd1);
    sb_q.push_back(PT_R);
    send_frame(1'b0, 128'd0, PT_R, 1'b0);
    chk("post_rst_key0", aes_key, 128'd0);
    check_latency("prst");
    check_back_to_idle("prst");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
